// File: rtl/gd_pkg.sv
// Shared widths, FIFO entry layout and a width helper for the Goldschmidt multiplier datapath.
package gd_pkg;

    localparam int GD_DATA_W = 32;
    localparam int GD_MANT_W = 24;
    localparam int GD_TAG_W  = 4;

    typedef struct packed {
        logic [GD_TAG_W-1:0]  tag;
        logic [GD_MANT_W-1:0] a_mant;
        logic [GD_MANT_W-1:0] b_mant;
    } gd_entry_t;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int gd_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/gd_mul_pipe.sv
// Pipelined unsigned MANT_W x MANT_W multiplier carrying valid and tag alongside the data.
// Latency: MUL_STAGES cycles from issue to result.
// Backpressure: en low freezes every stage (data, tag, valid) in place.
module gd_mul_pipe
    import gd_pkg::*;
#(
    parameter int MANT_W     = GD_MANT_W,
    parameter int TAG_W      = GD_TAG_W,
    parameter int MUL_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  issue_vld,
    input  logic [MANT_W-1:0]     a_mant,
    input  logic [MANT_W-1:0]     b_mant,
    input  logic [TAG_W-1:0]      issue_tag,
    output logic                  res_vld,
    output logic [2*MANT_W-1:0]   res_dat,
    output logic [TAG_W-1:0]      res_tag
);

    localparam int PROD_W = 2 * MANT_W;

    logic             vld_q [MUL_STAGES];
    logic [TAG_W-1:0] tag_q [MUL_STAGES];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= '0;
            end
        end else if (en) begin
            vld_q[0] <= issue_vld;
            tag_q[0] <= issue_tag;
            for (int i = 1; i < MUL_STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign res_vld = vld_q[MUL_STAGES-1];
    assign res_tag = tag_q[MUL_STAGES-1];

    generate
        if (MUL_STAGES == 1) begin : g_single
            logic [PROD_W-1:0] prod_q;

            always_ff @(posedge clk) begin
                if (clear) begin
                    prod_q <= '0;
                end else if (en) begin
                    prod_q <= {{MANT_W{1'b0}}, a_mant} * {{MANT_W{1'b0}}, b_mant};
                end
            end

            assign res_dat = prod_q;
        end else begin : g_split
            // Stage 1 forms two half-width partial products; stage 2 recombines them exactly.
            localparam int LO_W = MANT_W / 2;
            localparam int HI_W = MANT_W - LO_W;

            logic [MANT_W+LO_W-1:0] pp_lo_q;
            logic [MANT_W+HI_W-1:0] pp_hi_q;
            logic [PROD_W-1:0]      prod_q [MUL_STAGES-1];

            always_ff @(posedge clk) begin
                if (clear) begin
                    pp_lo_q <= '0;
                    pp_hi_q <= '0;
                    for (int i = 0; i < MUL_STAGES - 1; i++) begin
                        prod_q[i] <= '0;
                    end
                end else if (en) begin
                    pp_lo_q   <= {{LO_W{1'b0}}, a_mant} * {{MANT_W{1'b0}}, b_mant[LO_W-1:0]};
                    pp_hi_q   <= {{HI_W{1'b0}}, a_mant} * {{MANT_W{1'b0}}, b_mant[MANT_W-1:LO_W]};
                    prod_q[0] <= {{HI_W{1'b0}}, pp_lo_q} + ({{LO_W{1'b0}}, pp_hi_q} << LO_W);
                    for (int i = 1; i < MUL_STAGES - 1; i++) begin
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end

            assign res_dat = prod_q[MUL_STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/gd_mul_stream.sv
// Operand-buffering multiplier: DEPTH-entry FWFT FIFO feeding a MUL_STAGES-deep exact multiplier.
// Latency: MUL_STAGES+1 cycles from accept to product when the output is not stalled.
// Backpressure: out_ready low freezes the pipe and FIFO pops; in_ready drops only when the FIFO is full.
module gd_mul_stream
    import gd_pkg::*;
#(
    parameter int DATA_W     = GD_DATA_W,
    parameter int MANT_W     = GD_MANT_W,
    parameter int DEPTH      = 4,
    parameter int MUL_STAGES = 3,
    parameter int TAG_W      = GD_TAG_W
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          a_in,
    input  logic [DATA_W-1:0]          b_in,
    input  logic [TAG_W-1:0]           tag_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*MANT_W-1:0]        product,
    output logic [TAG_W-1:0]           tag_out,
    output logic [gd_clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = gd_clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [MANT_W-1:0] a_mant;
        logic [MANT_W-1:0] b_mant;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;
    logic             advance;

    // Ready comes from registered count only, so a same-cycle pop never opens room for a push.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign advance  = !out_valid || out_ready;
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && advance;

    assign wr_entry = '{tag: tag_in, a_mant: a_in[MANT_W-1:0], b_mant: b_in[MANT_W-1:0]};
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign fifo_count = count_q;

    gd_mul_pipe #(
        .MANT_W     (MANT_W),
        .TAG_W      (TAG_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_pipe (
        .clk       (clk),
        .clear     (clear),
        .en        (advance),
        .issue_vld (pop),
        .a_mant    (head.a_mant),
        .b_mant    (head.b_mant),
        .issue_tag (head.tag),
        .res_vld   (out_valid),
        .res_dat   (product),
        .res_tag   (tag_out)
    );

    generate
        if (DATA_W > MANT_W) begin : g_hi_bits
            // Exponent/sign bits above the mantissa are deliberately dropped.
            logic unused_hi_bits;
            assign unused_hi_bits = ^{a_in[DATA_W-1:MANT_W], b_in[DATA_W-1:MANT_W]};
        end
    endgenerate

endmodule

// File: tb/tb_gd_mul_stream.sv
// Bench for gd_mul_stream: default build and a DEPTH=2/MUL_STAGES=1 build share one stimulus stream.
// Latency: each build is compared every cycle against a queue-based model of the FIFO and pipe.
// Backpressure: out_ready is toggled and randomized; model stalls follow the same hold rule.
module tb_gd_mul_stream;

    typedef struct {
        logic [47:0] p;
        logic [3:0]  t;
    } item_t;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic [3:0]  tag_in = '0;

    logic [1:0]  in_rdy;
    logic [1:0]  ov;
    logic [47:0] prod  [2];
    logic [3:0]  tag_o [2];
    logic [2:0]  cnt   [2];

    bit run = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int DEP = (k == 0) ? 4 : 2;
        localparam int STG = (k == 0) ? 3 : 1;

        logic                   in_rdy_l;
        logic                   ov_l;
        logic [47:0]            prod_l;
        logic [3:0]             tag_l;
        logic [$clog2(DEP):0]   cnt_l;

        gd_mul_stream #(
            .DATA_W     (32),
            .MANT_W     (24),
            .DEPTH      (DEP),
            .MUL_STAGES (STG),
            .TAG_W      (4)
        ) dut (
            .clk        (clk),
            .clear      (clear),
            .in_valid   (in_valid),
            .in_ready   (in_rdy_l),
            .a_in       (a_in),
            .b_in       (b_in),
            .tag_in     (tag_in),
            .out_valid  (ov_l),
            .out_ready  (out_ready),
            .product    (prod_l),
            .tag_out    (tag_l),
            .fifo_count (cnt_l)
        );

        assign in_rdy[k] = in_rdy_l;
        assign ov[k]     = ov_l;
        assign prod[k]   = prod_l;
        assign tag_o[k]  = tag_l;
        assign cnt[k]    = 3'(cnt_l);

        // Model: buffered items in a queue, multiplier as STG slots; the last slot is the output.
        item_t q[$];
        item_t s_p [STG];
        bit    s_v [STG];
        bit    adv;
        bit    acc;
        item_t it;

        always @(posedge clk) begin
            if (clear) begin
                q.delete();
                for (int i = 0; i < STG; i++) s_v[i] = 1'b0;
            end else begin
                adv = !s_v[STG-1] || out_ready;
                acc = in_valid && (q.size() < DEP);
                if (adv) begin
                    for (int i = STG - 1; i > 0; i--) begin
                        s_v[i] = s_v[i-1];
                        s_p[i] = s_p[i-1];
                    end
                    if (q.size() != 0) begin
                        s_v[0] = 1'b1;
                        s_p[0] = q.pop_front();
                    end else begin
                        s_v[0] = 1'b0;
                    end
                end
                if (acc) begin
                    it.p = 48'(a_in[23:0]) * 48'(b_in[23:0]);
                    it.t = tag_in;
                    q.push_back(it);
                end
            end
        end

        always @(negedge clk) begin
            if (run) begin
                chk($sformatf("in_ready[%0d]", k), 64'(in_rdy_l), 64'(q.size() != DEP));
                chk($sformatf("fifo_count[%0d]", k), 64'(cnt_l), 64'(q.size()));
                chk($sformatf("out_valid[%0d]", k), 64'(ov_l), 64'(s_v[STG-1]));
                if (s_v[STG-1]) begin
                    chk($sformatf("product[%0d]", k), 64'(prod_l), 64'(s_p[STG-1].p));
                    chk($sformatf("tag_out[%0d]", k), 64'(tag_l), 64'(s_p[STG-1].t));
                end
            end
        end
    end

    initial begin
        int          lat0, lat1, pulses0, run0, run1, ng, stray;
        bit          gap0, gap1;
        logic [47:0] p0;
        logic [3:0]  t0;
        logic [47:0] got [2];

        // Reset state
        clear = 1'b1;
        tick();
        run = 1'b1;
        tick();
        clear = 1'b0;
        chk("reset in_ready", 64'(in_rdy[0]), 64'd1);
        chk("reset in_ready small", 64'(in_rdy[1]), 64'd1);
        chk("reset fifo_count", 64'(cnt[0]), 64'd0);
        chk("reset out_valid", 64'(ov[0]), 64'd0);
        chk("reset product", 64'(prod[0]), 64'd0);
        chk("reset tag_out", 64'(tag_o[0]), 64'd0);

        // 1.0 x 1.0 mantissas: single product, latency = MUL_STAGES edges after accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_in      = 32'h3F80_0000;
        b_in      = 32'h3F80_0000;
        tag_in    = 4'd1;
        tick();
        in_valid = 1'b0;
        lat0 = -1; lat1 = -1; pulses0 = 0; p0 = '0; t0 = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (ov[0]) begin
                pulses0++;
                if (lat0 < 0) begin
                    lat0 = c;
                    p0 = prod[0];
                    t0 = tag_o[0];
                end
            end
            if (ov[1] && lat1 < 0) lat1 = c;
        end
        chk("latency default", 64'(lat0), 64'd3);
        chk("latency small", 64'(lat1), 64'd1);
        chk("unit product", 64'(p0), 64'h4000_0000_0000);
        chk("unit tag", 64'(t0), 64'd1);
        chk("unit pulse count", 64'(pulses0), 64'd1);

        // Fill with out_ready low until both builds are full
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_in     = $urandom;
            b_in     = $urandom;
            tag_in   = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("full count default", 64'(cnt[0]), 64'd4);
        chk("full in_ready default", 64'(in_rdy[0]), 64'd0);
        chk("full count small", 64'(cnt[1]), 64'd2);
        chk("full in_ready small", 64'(in_rdy[1]), 64'd0);
        chk("stalled out_valid", 64'(ov[0]), 64'd1);

        // Drain: products must stream back-to-back with no gaps
        out_ready = 1'b1;
        run0 = 0; run1 = 0; gap0 = 1'b0; gap1 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (ov[0] && !gap0) run0++; else gap0 = 1'b1;
            if (ov[1] && !gap1) run1++; else gap1 = 1'b1;
            tick();
        end
        chk("drain run default", 64'(run0), 64'd7);
        chk("drain run small", 64'(run1), 64'd3);

        // Max mantissas, with and without upper bits set
        in_valid = 1'b1;
        a_in = 32'h00FF_FFFF; b_in = 32'h00FF_FFFF; tag_in = 4'd6;
        tick();
        a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; tag_in = 4'd7;
        tick();
        in_valid = 1'b0;
        ng = 0; got[0] = '0; got[1] = '0;
        for (int c = 0; c < 10; c++) begin
            if (ov[0] && ng < 2) begin
                got[ng] = prod[0];
                ng++;
            end
            tick();
        end
        chk("max operand count", 64'(ng), 64'd2);
        chk("max product", 64'(got[0]), 64'hFFFF_FE00_0001);
        chk("max product upper bits ignored", 64'(got[1]), 64'hFFFF_FE00_0001);

        // Clear with three buffered and three in flight
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            a_in     = $urandom;
            b_in     = $urandom;
            tag_in   = 4'(i + 8);
            tick();
        end
        in_valid = 1'b0;
        chk("pre-clear count", 64'(cnt[0]), 64'd3);
        chk("pre-clear out_valid", 64'(ov[0]), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("post-clear out_valid", 64'(ov[0]), 64'd0);
        chk("post-clear count", 64'(cnt[0]), 64'd0);
        chk("post-clear in_ready", 64'(in_rdy[0]), 64'd1);
        chk("post-clear product", 64'(prod[0]), 64'd0);
        out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (ov[0] || ov[1]) stray++;
        end
        chk("nothing after clear", 64'(stray), 64'd0);

        // Random traffic: toggling out_ready first, then random stalls and occasional clears
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a_in     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            b_in     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            tag_in   = 4'($urandom);
            if (c < 300) out_ready = c[0];
            else         out_ready = ($urandom_range(0, 2) != 0);
            clear    = ($urandom_range(0, 399) == 0);
            tick();
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("final count default", 64'(cnt[0]), 64'd0);
        chk("final out_valid default", 64'(ov[0]), 64'd0);
        chk("final count small", 64'(cnt[1]), 64'd0);
        chk("final out_valid small", 64'(ov[1]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
